// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side blocks.
// Holds the transmitter state encoding, error codes, common command bytes,
// the latched frame payload type and the odd-parity helper.
package ps2_pkg;

    // Width of the shared inhibit / timeout counter (covers 15 ms at 50 MHz).
    localparam int unsigned CNT_W = 20;

    // Released open-drain lines float high.
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NACK    = 2'b10;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    // Command byte as latched on accept, with its parity bit.
    typedef struct packed {
        logic [7:0] data;
        logic       parity;
    } ps2_tx_frame_t;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioner: 2-flop synchronizers on clock and data, optional
// clock glitch filter, and falling-edge detect on the (filtered) clock.
// Optional feature: define PS2_TX_FILTER_EN to enable the clock filter.
// Ports:
//   clk, reset_n   system clock, async active-low reset
//   i_clk_raw      raw PS2_CLK pin level
//   i_dat_raw      raw PS2_DAT pin level
//   o_clk_lvl      conditioned clock level
//   o_dat_lvl      synchronized data level
//   o_clk_fall_c   single-cycle falling-edge strobe (combinational)
module ps2_line_sync
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clk_raw,
    input  logic i_dat_raw,
    output logic o_clk_lvl,
    output logic o_dat_lvl,
    output logic o_clk_fall_c
);

    logic [1:0] r_clk_sync;
    logic [1:0] r_dat_sync;
    logic       r_clk_prev;
    logic       w_clk_lvl;

    // Metastability synchronizers and previous-level register for edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_sync <= {2{LINE_IDLE}};
            r_dat_sync <= {2{LINE_IDLE}};
            r_clk_prev <= LINE_IDLE;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_clk_raw};
            r_dat_sync <= {r_dat_sync[0], i_dat_raw};
            r_clk_prev <= w_clk_lvl;
        end
    end

`ifdef PS2_TX_FILTER_EN
    localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);

    logic [FCNT_W-1:0] r_fcnt;
    logic              r_clk_filt;

    // Level flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fcnt     <= '0;
            r_clk_filt <= LINE_IDLE;
        end else if (r_clk_sync[1] == r_clk_filt) begin
            r_fcnt <= '0;
        end else if (r_fcnt == FCNT_W'(FILTER_LEN - 1)) begin
            r_clk_filt <= r_clk_sync[1];
            r_fcnt     <= '0;
        end else begin
            r_fcnt <= r_fcnt + 1'b1;
        end
    end

    assign w_clk_lvl = r_clk_filt;
`else
    logic w_filter_len_unused;

    assign w_filter_len_unused = (FILTER_LEN != 0);
    assign w_clk_lvl           = r_clk_sync[1];
`endif

    assign o_clk_lvl    = w_clk_lvl;
    assign o_dat_lvl    = r_dat_sync[1];
    assign o_clk_fall_c = r_clk_prev & ~w_clk_lvl;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Inhibits the bus, issues a request-to-send, clocks out 8 data bits LSB
// first plus odd parity and stop on device clock falling edges, then checks
// the device ACK. Lines are driven through active-high pull-low enables.
// Optional feature: PS2_TX_FILTER_EN enables the device clock glitch filter.
// Ports:
//   clk, reset_n           50 MHz clock, async active-low reset
//   tx_data/tx_valid       command byte and request
//   tx_ready               high only when idle
//   ps2_clk_in/ps2_dat_in  raw pin levels
//   ps2_clk_oe/ps2_dat_oe  1 = pull line low
//   busy                   high while a frame is in flight
//   done/error             one-cycle completion pulses
//   err_code               00 none, 01 timeout, 10 NACK
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

    ps2_tx_state_e r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_idx, w_idx_nxt;
    ps2_tx_frame_t    r_frame, w_frame_nxt;
    logic             r_clk_oe, w_clk_oe_nxt;
    logic             r_dat_oe, w_dat_oe_nxt;
    logic             r_tx_ready, w_tx_ready_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_error, w_error_nxt;
    logic [1:0]       r_err_code, w_err_code_nxt;
    logic             w_abort;

    logic w_clk_lvl;
    logic w_dat_lvl;
    logic w_clk_fall;
    logic w_timeout;
    logic w_inh_last;

    ps2_line_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sync (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_clk_raw    (ps2_clk_in),
        .i_dat_raw    (ps2_dat_in),
        .o_clk_lvl    (w_clk_lvl),
        .o_dat_lvl    (w_dat_lvl),
        .o_clk_fall_c (w_clk_fall)
    );

    assign w_timeout  = (r_cnt >= CNT_W'(TIMEOUT_CYCLES));
    assign w_inh_last = (r_cnt == CNT_W'(INHIBIT_CYCLES - 1));

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_frame    <= '0;
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_frame    <= w_frame_nxt;
            r_clk_oe   <= w_clk_oe_nxt;
            r_dat_oe   <= w_dat_oe_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_frame_nxt    = r_frame;
        w_clk_oe_nxt   = r_clk_oe;
        w_dat_oe_nxt   = r_dat_oe;
        w_done_nxt     = 1'b0;
        w_error_nxt    = 1'b0;
        w_err_code_nxt = r_err_code;
        w_abort        = 1'b0;
        // Timed states reload on every device edge and count otherwise.
        w_cnt_nxt      = w_clk_fall ? '0 : r_cnt + 1'b1;

        unique case (r_state)
            IDLE: begin
                w_cnt_nxt    = r_cnt;
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                if (tx_valid) begin
                    w_frame_nxt.data   = tx_data;
                    w_frame_nxt.parity = odd_parity(tx_data);
                    w_err_code_nxt     = ERR_NONE;
                    w_cnt_nxt          = '0;
                    w_clk_oe_nxt       = 1'b1;
                    w_state_nxt        = INHIBIT;
                end
            end
            INHIBIT: begin
                if (w_inh_last) begin
                    // Start bit goes low while the clock is still held.
                    w_cnt_nxt    = '0;
                    w_dat_oe_nxt = 1'b1;
                    w_state_nxt  = REQ;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            REQ: begin
                w_cnt_nxt    = r_cnt + 1'b1;
                w_clk_oe_nxt = 1'b0;
                w_idx_nxt    = '0;
                w_state_nxt  = DATA;
            end
            DATA: begin
                if (w_clk_fall) begin
                    w_dat_oe_nxt = ~r_frame.data[r_idx];
                    w_idx_nxt    = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = PARITY;
                    end
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                end
            end
            PARITY: begin
                if (w_clk_fall) begin
                    w_dat_oe_nxt = ~r_frame.parity;
                    w_state_nxt  = STOP;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                end
            end
            STOP: begin
                if (w_clk_fall) begin
                    w_dat_oe_nxt = 1'b0;
                    w_state_nxt  = ACK;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                end
            end
            ACK: begin
                if (w_clk_fall) begin
                    if (w_dat_lvl) begin
                        w_clk_oe_nxt   = 1'b0;
                        w_dat_oe_nxt   = 1'b0;
                        w_err_code_nxt = ERR_NACK;
                        w_error_nxt    = 1'b1;
                        w_state_nxt    = IDLE;
                    end else begin
                        w_state_nxt = WAIT_IDLE;
                    end
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (w_clk_lvl && w_dat_lvl) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (!w_clk_fall && w_timeout) begin
                    w_abort = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_abort) begin
            w_clk_oe_nxt   = 1'b0;
            w_dat_oe_nxt   = 1'b0;
            w_err_code_nxt = ERR_TIMEOUT;
            w_error_nxt    = 1'b1;
            w_state_nxt    = IDLE;
        end

        w_tx_ready_nxt = (w_state_nxt == IDLE);
        w_busy_nxt     = (w_state_nxt != IDLE);
    end

    assign tx_ready   = r_tx_ready;
    assign busy       = r_busy;
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;
    assign done       = r_done;
    assign error      = r_error;
    assign err_code   = r_err_code;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

    localparam int unsigned INH = 40;
    localparam int unsigned TMO = 1500;
    localparam int unsigned FLT = 8;

    logic       clk;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    logic       dev_clk_low;
    logic       dev_dat_low;

    // Wired-AND bus: either side may pull a line low.
    assign ps2_clk_in = ~ps2_clk_oe & ~dev_clk_low;
    assign ps2_dat_in = ~ps2_dat_oe & ~dev_dat_low;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    int   ev_cnt = 0;
    int   ev_cyc = 0;
    int   n_done = 0;
    int   n_err  = 0;
    int   n_both = 0;
    int   n_wide = 0;
    logic ev_done, ev_err, ev_ready, ev_busy, ev_clk_oe, ev_dat_oe;
    logic [1:0] ev_code;
    logic prev_pulse = 1'b0;
    int   exp_done = 0;
    int   exp_err  = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every done/error pulse with a snapshot of the outputs at that cycle.
    always @(negedge clk) begin
        if (done || error) begin
            ev_cnt    <= ev_cnt + 1;
            ev_cyc    <= cyc;
            ev_done   <= done;
            ev_err    <= error;
            ev_ready  <= tx_ready;
            ev_busy   <= busy;
            ev_clk_oe <= ps2_clk_oe;
            ev_dat_oe <= ps2_dat_oe;
            ev_code   <= err_code;
        end
        if (done)              n_done <= n_done + 1;
        if (error)             n_err  <= n_err + 1;
        if (done && error)     n_both <= n_both + 1;
        if ((done || error) && prev_pulse) n_wide <= n_wide + 1;
        prev_pulse <= done || error;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got cycle %0d expected finish", cyc);
        $fatal(1, "bench watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected 11-bit line sequence: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int v;
        int ones;
        int b;
        v    = 0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            b    = (int'(d) >> i) & 1;
            ones = ones + b;
            v    = v + (b << (i + 1));
        end
        v = v + (((ones % 2) == 0 ? 1 : 0) << 9);
        v = v + (1 << 10);
        return 11'(v);
    endfunction

    task automatic accept_and_inhibit(input logic [7:0] d, output int rel_cyc);
        int   n_hi;
        int   n_pre;
        logic last;
        @(negedge clk);
        check_eq("ready_pre", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check_eq("busy_acc", 32'(busy), 32'd1);
        check_eq("errclr", 32'(err_code), 32'd0);
        n_hi  = 0;
        n_pre = 0;
        last  = 1'b0;
        while (ps2_clk_oe && n_hi < int'(INH) + 50) begin
            n_hi++;
            if (!ps2_dat_oe) n_pre++;
            last = ps2_dat_oe;
            @(negedge clk);
        end
        check_eq("clk_low_len", 32'(n_hi), 32'(INH + 1));
        check_eq("dat_before_rel", 32'(n_pre), 32'(INH));
        check_eq("dat_fell_first", 32'(last), 32'd1);
        rel_cyc = cyc;
    endtask

    // Device: generates nedges clock pulses and samples data before each rising edge.
    task automatic device_run(input bit ack, input int half, input int nedges,
                              input bit poke, output logic [10:0] obs);
        obs    = '0;
        obs[0] = ps2_dat_in;
        repeat (half) @(negedge clk);
        for (int k = 1; k <= nedges; k++) begin
            dev_clk_low = 1'b1;
            for (int j = 0; j < half; j++) begin
                @(negedge clk);
                if (poke && k == 4) begin
                    tx_valid = (j == 0);
                    tx_data  = 8'h55;
                end
            end
            if (k <= 10) obs[k] = ps2_dat_in;
            dev_clk_low = 1'b0;
            if (k == 10 && ack) begin
                repeat (half / 2) @(negedge clk);
                dev_dat_low = 1'b1;
                repeat (half - half / 2) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_event(input int start, input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            if (ev_cnt != start) seen = 1'b1;
            else @(negedge clk);
        end
        check_eq("evt_seen", 32'(seen), 32'd1);
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input int half,
                             input bit poke, output logic [10:0] obs);
        int  rel;
        int  start;
        bit  seen;
        start = ev_cnt;
        accept_and_inhibit(d, rel);
        device_run(ack, half, 11, poke, obs);
        check_eq("frame_bits", 32'(obs), 32'(model_frame(d)));
        wait_event(start, 200, seen);
        if (ack) begin
            exp_done++;
            check_eq("done_evt", 32'(ev_done), 32'd1);
            check_eq("code_ack", 32'(ev_code), 32'd0);
        end else begin
            exp_err++;
            check_eq("error_evt", 32'(ev_err), 32'd1);
            check_eq("code_nack", 32'(ev_code), 32'd2);
        end
        check_eq("ready_at_evt", 32'(ev_ready), 32'd1);
        check_eq("busy_at_evt", 32'(ev_busy), 32'd0);
        check_eq("oe_at_evt", 32'({ev_clk_oe, ev_dat_oe}), 32'd0);
    endtask

    initial begin
        logic [10:0] obs;
        logic [7:0]  d;
        int          rel;
        int          start;
        bit          seen;
        int          half;
        bit          ack;

        reset_n     = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(tx_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        check_eq("rst_pulses", 32'({done, error}), 32'd0);
        check_eq("rst_code", 32'(err_code), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", 32'(tx_ready), 32'd1);

        // Set-LEDs command with ACK.
        run_frame(ps2_pkg::CMD_SET_LEDS, 1'b1, 20, 1'b0, obs);
        check_eq("ed_const", 32'(obs), 32'h7DA);

        // Parity of 0x00 and 0x01, back to back.
        run_frame(8'h00, 1'b1, 18, 1'b0, obs);
        check_eq("par_00", 32'(obs[9]), 32'd1);
        check_eq("ready_b2b", 32'(tx_ready), 32'd1);
        run_frame(8'h01, 1'b1, 18, 1'b0, obs);
        check_eq("par_01", 32'(obs[9]), 32'd0);

        // Device refuses the frame.
        d = 8'($urandom);
        run_frame(d, 1'b0, 20, 1'b0, obs);
        repeat (20) @(negedge clk);
        check_eq("err_hold", 32'(err_code), 32'd2);

        // No device clock after release.
        start = ev_cnt;
        accept_and_inhibit(ps2_pkg::CMD_RESET, rel);
        wait_event(start, int'(TMO) + 100, seen);
        exp_err++;
        check_eq("tmo_error", 32'(ev_err), 32'd1);
        check_eq("tmo_latency", 32'(ev_cyc - rel), 32'(TMO));
        check_eq("tmo_code", 32'(ev_code), 32'd1);
        check_eq("tmo_oe", 32'({ev_clk_oe, ev_dat_oe}), 32'd0);
        check_eq("tmo_ready", 32'(ev_ready), 32'd1);

        // Request pulsed mid-frame must be ignored.
        d = 8'($urandom);
        run_frame(d, 1'b1, 25, 1'b1, obs);
        repeat (30) @(negedge clk);
        check_eq("no_second", 32'({busy, ps2_clk_oe}), 32'd0);

        // Reset while data bit 4 (a zero) is on the line.
        d = 8'($urandom) & 8'hEF;
        accept_and_inhibit(d, rel);
        device_run(1'b1, 20, 5, 1'b0, obs);
        check_eq("pre_rst_dat", 32'(ps2_dat_oe), 32'd1);
        check_eq("bits_pre_rst", 32'(obs[5:0]), 32'(model_frame(d) & 11'h03F));
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        check_eq("async_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        run_frame(ps2_pkg::CMD_ENABLE, 1'b1, 20, 1'b0, obs);

        // Randomized frames.
        for (int n = 0; n < 6; n++) begin
            d    = 8'($urandom);
            half = int'($urandom_range(16, 30));
            ack  = ($urandom_range(0, 4) != 0);
            run_frame(d, ack, half, 1'b0, obs);
        end

        repeat (5) @(negedge clk);
        check_eq("n_done", 32'(n_done), 32'(exp_done));
        check_eq("n_error", 32'(n_err), 32'(exp_err));
        check_eq("done_and_error", 32'(n_both), 32'd0);
        check_eq("pulse_width", 32'(n_wide), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
